// File: rtl/axi_master.sv
// axi_master: single-outstanding AXI3-style INCR burst initiator.
//
// Takes one read or write command at a time from the cmd_* port. It then
// drives one AXI burst of 1-16 beats on a 32-bit bus and signals the end
// with a one-cycle done_valid pulse. Write beats come from the wd_* port,
// and read beats go out on the rd_* port. A burst always ends by beat
// count; the slave's rlast is never used to terminate it.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   cmd_*                     command handshake and fields (addr/len/id/write)
//   wd_*                      write-data stream in (data, strobes, valid/ready)
//   rd_*                      read-data stream out (data, last, valid/ready)
//   done_*                    completion pulse with write flag, response, ID
//   lastchk_err               sticky flag: slave rlast disagreed with beat count
//   o_aw*/i_awready           AW channel
//   o_w*/i_wready             W channel
//   i_b*/o_bready             B channel (i_bid ignored)
//   o_ar*/i_arready           AR channel
//   i_r*/o_rready             R channel (i_rid ignored)
//
// Build option: define AXI_MASTER_LASTCHK_EN to check i_rlast on every read
// beat. A mismatch sets lastchk_err and forces that command's done_resp to
// SLVERR. Without the macro, i_rlast is ignored and lastchk_err stays 0.
module axi_master #(
  parameter int unsigned AXI_ID_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  // command port
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [31:0]             cmd_addr,
  input  logic [3:0]              cmd_len,
  input  logic [AXI_ID_WIDTH-1:0] cmd_id,
  // write-data stream
  input  logic [31:0]             wd_data,
  input  logic [3:0]              wd_strb,
  input  logic                    wd_valid,
  output logic                    wd_ready,
  // read-data stream
  output logic [31:0]             rd_data,
  output logic                    rd_last,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  // completion
  output logic                    done_valid,
  output logic                    done_write,
  output logic [1:0]              done_resp,
  output logic [AXI_ID_WIDTH-1:0] done_id,
  output logic                    lastchk_err,
  // AW channel
  output logic [31:0]             o_awaddr,
  output logic [AXI_ID_WIDTH-1:0] o_awid,
  output logic [3:0]              o_awlen,
  output logic                    o_awvalid,
  input  logic                    i_awready,
  // W channel
  output logic [31:0]             o_wdata,
  output logic [AXI_ID_WIDTH-1:0] o_wid,
  output logic [3:0]              o_wstrb,
  output logic                    o_wlast,
  output logic                    o_wvalid,
  input  logic                    i_wready,
  // B channel
  input  logic [1:0]              i_bresp,
  input  logic [AXI_ID_WIDTH-1:0] i_bid,
  input  logic                    i_bvalid,
  output logic                    o_bready,
  // AR channel
  output logic [31:0]             o_araddr,
  output logic [AXI_ID_WIDTH-1:0] o_arid,
  output logic [3:0]              o_arlen,
  output logic                    o_arvalid,
  input  logic                    i_arready,
  // R channel
  input  logic [31:0]             i_rdata,
  input  logic [AXI_ID_WIDTH-1:0] i_rid,
  input  logic [1:0]              i_rresp,
  input  logic                    i_rlast,
  input  logic                    i_rvalid,
  output logic                    o_rready
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned RESP_W = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q,  addr_d;
  logic [LEN_W-1:0]        len_q,   len_d;
  logic [AXI_ID_WIDTH-1:0] id_q,    id_d;
  logic                    write_q, write_d;
  logic [LEN_W-1:0]        cnt_q,   cnt_d;
  logic [RESP_W-1:0]       resp_q,  resp_d;
  logic                    lerr_q,  lerr_d;   // sticky rlast mismatch
  logic                    lbad_q,  lbad_d;   // mismatch seen in current command
  logic                    beat_last;

  // Slave-side IDs are not checked; this signal exists only to consume them.
  logic unused_inputs;
  assign unused_inputs = ^{i_bid, i_rid, i_rlast};

  assign beat_last = (cnt_q == len_q);

  // Command fields are held in registers for the whole burst.
  assign o_awaddr    = addr_q;
  assign o_awlen     = len_q;
  assign o_awid      = id_q;
  assign o_araddr    = addr_q;
  assign o_arlen     = len_q;
  assign o_arid      = id_q;
  assign o_wid       = id_q;
  assign done_write  = write_q;
  assign done_id     = id_q;
  assign done_resp   = lbad_q ? RESP_W'(2'b10) : resp_q;
  assign lastchk_err = lerr_q;

  // State register and command/beat bookkeeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
      write_q <= 1'b0;
      cnt_q   <= '0;
      resp_q  <= '0;
      lerr_q  <= 1'b0;
      lbad_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      id_q    <= id_d;
      write_q <= write_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      lerr_q  <= lerr_d;
      lbad_q  <= lbad_d;
    end
  end

  // Next-state and channel handshake decode.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    id_d       = id_q;
    write_d    = write_q;
    cnt_d      = cnt_q;
    resp_d     = resp_q;
    lerr_d     = lerr_q;
    lbad_d     = lbad_q;
    cmd_ready  = 1'b0;
    o_awvalid  = 1'b0;
    o_wvalid   = 1'b0;
    o_wdata    = '0;
    o_wstrb    = '0;
    o_wlast    = 1'b0;
    wd_ready   = 1'b0;
    o_bready   = 1'b0;
    o_arvalid  = 1'b0;
    o_rready   = 1'b0;
    rd_valid   = 1'b0;
    rd_data    = '0;
    rd_last    = 1'b0;
    done_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          id_d    = cmd_id;
          write_d = cmd_write;
          cnt_d   = '0;
          resp_d  = '0;
          lbad_d  = 1'b0;
          state_d = cmd_write ? S_AW : S_AR;
        end
      end
      S_AW: begin
        o_awvalid = 1'b1;
        if (i_awready) state_d = S_W;
      end
      S_W: begin
        o_wvalid = wd_valid;
        wd_ready = i_wready;
        o_wdata  = wd_data;
        o_wstrb  = wd_strb;
        o_wlast  = beat_last;
        if (wd_valid && i_wready) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (beat_last) state_d = S_B;
        end
      end
      S_B: begin
        o_bready = 1'b1;
        if (i_bvalid) begin
          resp_d  = i_bresp;
          state_d = S_DONE;
        end
      end
      S_AR: begin
        o_arvalid = 1'b1;
        if (i_arready) state_d = S_R;
      end
      S_R: begin
        rd_valid = i_rvalid;
        o_rready = rd_ready;
        rd_data  = i_rdata;
        rd_last  = beat_last;
        if (i_rvalid && rd_ready) begin
          cnt_d = cnt_q + LEN_W'(1);
          // Worst response across the burst is reported.
          if (i_rresp > resp_q) resp_d = i_rresp;
`ifdef AXI_MASTER_LASTCHK_EN
          if (i_rlast != beat_last) begin
            lerr_d = 1'b1;
            lbad_d = 1'b1;
          end
`endif
          if (beat_last) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_master.sv
// Self-checking bench for axi_master with a small AXI slave model.
// The slave raises its B or R response one cycle after it has registered
// the request. With this slave, done for a write of len L is observed in the
// cycle that ends at edge N+L+5, and for a read in the cycle ending at N+L+4.
// Here N is the accept edge. Seen from the negedge inside that cycle, the
// distance is L+4 and L+3 edges.
module tb_axi_master;

  localparam int unsigned IDW = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic            cmd_valid, cmd_ready, cmd_write;
  logic [31:0]     cmd_addr;
  logic [3:0]      cmd_len;
  logic [IDW-1:0]  cmd_id;
  logic [31:0]     wd_data;
  logic [3:0]      wd_strb;
  logic            wd_valid, wd_ready;
  logic [31:0]     rd_data;
  logic            rd_last, rd_valid, rd_ready;
  logic            done_valid, done_write;
  logic [1:0]      done_resp;
  logic [IDW-1:0]  done_id;
  logic            lastchk_err;
  logic [31:0]     o_awaddr, o_wdata, o_araddr, i_rdata;
  logic [IDW-1:0]  o_awid, o_wid, o_arid, i_bid, i_rid;
  logic [3:0]      o_awlen, o_wstrb, o_arlen;
  logic            o_awvalid, i_awready, o_wlast, o_wvalid, i_wready;
  logic [1:0]      i_bresp, i_rresp;
  logic            i_bvalid, o_bready, o_arvalid, i_arready;
  logic            i_rlast, i_rvalid, o_rready;

  axi_master #(.AXI_ID_WIDTH(IDW)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wd_data(wd_data), .wd_strb(wd_strb), .wd_valid(wd_valid), .wd_ready(wd_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done_valid(done_valid), .done_write(done_write), .done_resp(done_resp),
    .done_id(done_id), .lastchk_err(lastchk_err),
    .o_awaddr(o_awaddr), .o_awid(o_awid), .o_awlen(o_awlen),
    .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wid(o_wid), .o_wstrb(o_wstrb), .o_wlast(o_wlast),
    .o_wvalid(o_wvalid), .i_wready(i_wready),
    .i_bresp(i_bresp), .i_bid(i_bid), .i_bvalid(i_bvalid), .o_bready(o_bready),
    .o_araddr(o_araddr), .o_arid(o_arid), .o_arlen(o_arlen),
    .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rid(i_rid), .i_rresp(i_rresp), .i_rlast(i_rlast),
    .i_rvalid(i_rvalid), .o_rready(o_rready)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- slave model ----------------
  logic        s_barm, s_bvalid, s_rarm, s_rvalid;
  logic [3:0]  s_rbeat, s_rlen;
  logic [31:0] s_raddr;
  logic [1:0]  bresp_val;
  logic [1:0]  rresp_tab [16];
  int          rlast_at;   // -1: rlast on the true last beat, else on that beat index

  function automatic logic [31:0] rdata_f(input logic [31:0] a, input logic [3:0] b);
    return a ^ (32'h0101_0101 * 32'(b)) ^ 32'hC0DE_0000;
  endfunction

  assign i_bvalid = s_bvalid;
  assign i_bresp  = bresp_val;
  assign i_bid    = 4'hF;
  assign i_rid    = 4'hE;
  assign i_rvalid = s_rvalid;
  assign i_rdata  = rdata_f(s_raddr, s_rbeat);
  assign i_rresp  = rresp_tab[s_rbeat];
  assign i_rlast  = s_rvalid && ((rlast_at < 0) ? (s_rbeat == s_rlen)
                                                : (int'(s_rbeat) == rlast_at));

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_barm <= 1'b0; s_bvalid <= 1'b0; s_rarm <= 1'b0; s_rvalid <= 1'b0;
      s_rbeat <= '0; s_rlen <= '0; s_raddr <= '0;
    end else begin
      if (s_barm) begin s_bvalid <= 1'b1; s_barm <= 1'b0; end
      if (o_wvalid && i_wready && o_wlast) s_barm <= 1'b1;
      if (s_bvalid && o_bready) s_bvalid <= 1'b0;
      if (o_arvalid && i_arready) begin
        s_raddr <= o_araddr; s_rlen <= o_arlen; s_rbeat <= '0; s_rarm <= 1'b1;
      end
      if (s_rarm) begin s_rvalid <= 1'b1; s_rarm <= 1'b0; end
      if (s_rvalid && o_rready) begin
        if (s_rbeat == s_rlen) s_rvalid <= 1'b0;
        else s_rbeat <= s_rbeat + 4'd1;
      end
    end
  end

  // ---------------- scoreboards ----------------
  logic [36:0]    wq [$];   // {last, strb, data}
  logic [32:0]    rq [$];   // {last, data}
  logic [36:0]    wexp;
  logic [32:0]    rexp;
  logic [IDW-1:0] cur_id;
  bit             mon_en = 1'b1;

  always @(negedge clk) begin
    if (mon_en && rstn && o_wvalid && i_wready) begin
      total++;
      if (wq.size() == 0) begin
        bad++;
        $display("FAIL w_beat: unexpected beat data=%h", o_wdata);
      end else begin
        wexp = wq.pop_front();
        if ({o_wlast, o_wstrb, o_wdata, o_wid} !== {wexp, cur_id}) begin
          bad++;
          $display("FAIL w_beat: got=%h want=%h", {o_wlast, o_wstrb, o_wdata, o_wid}, {wexp, cur_id});
        end
      end
    end
    if (mon_en && rstn && rd_valid && rd_ready) begin
      total++;
      if (rq.size() == 0) begin
        bad++;
        $display("FAIL r_beat: unexpected beat data=%h", rd_data);
      end else begin
        rexp = rq.pop_front();
        if ({rd_last, rd_data} !== rexp) begin
          bad++;
          $display("FAIL r_beat: got=%h want=%h", {rd_last, rd_data}, rexp);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_wbeats(input int n, input bit toggle);
    bit hs;
    for (int i = 0; i < n; i++) begin
      if (toggle && (i % 2 == 1)) begin
        wd_valid = 1'b0;
        @(posedge clk); #1;
      end
      wd_data  = $urandom;
      wd_strb  = 4'($urandom);
      wd_valid = 1'b1;
      wq.push_back({(i == n - 1), wd_strb, wd_data});
      hs = 1'b0;
      for (int t = 0; t < 200 && !hs; t++) begin
        @(negedge clk);
        hs = wd_ready;
        @(posedge clk); #1;
      end
      if (!hs) begin
        total++; bad++;
        $display("FAIL w_drive: beat %0d never accepted", i);
      end
    end
    wd_valid = 1'b0;
  endtask

  // Issues one command and waits for its completion; returns observations only.
  task automatic run_cmd(input bit w, input logic [31:0] a, input logic [3:0] l,
                         input logic [IDW-1:0] id, input bit toggle,
                         output logic [7:0] dv, output int lat, output int acc_c,
                         output int done_c, output logic rdy_at_done);
    bit acc, got;
    cur_id = id;
    cmd_write = w; cmd_addr = a; cmd_len = l; cmd_id = id; cmd_valid = 1'b1;
    dv = '0; lat = -1; done_c = 0; rdy_at_done = 1'bx;
    if (!w)
      for (int b = 0; b <= int'(l); b++) rq.push_back({(b == int'(l)), rdata_f(a, 4'(b))});
    if (w) fork send_wbeats(int'(l) + 1, toggle); join_none
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    acc_c = cyc;
    got = 1'b0;
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge clk);
      if (done_valid) begin
        got = 1'b1;
        dv = {1'b1, done_write, done_resp, done_id};
        done_c = cyc;
        rdy_at_done = cmd_ready;
      end
      @(posedge clk); #1;
    end
    lat = done_c - acc_c;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({cmd_ready, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, wd_ready,
         rd_valid, rd_last, o_wlast, done_valid, lastchk_err} !== 12'b1000_0000_0000) begin
      bad++;
      $display("FAIL reset_ctrl: got=%b want=100000000000",
        {cmd_ready, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, wd_ready,
         rd_valid, rd_last, o_wlast, done_valid, lastchk_err});
    end
    total++;
    if ({o_awaddr, o_araddr, o_awlen, o_arlen, o_awid, o_arid, o_wid, o_wdata,
         o_wstrb, rd_data, done_resp, done_id, done_write} !== '0) begin
      bad++;
      $display("FAIL reset_data: awaddr=%h araddr=%h awlen=%h wdata=%h rd_data=%h want all zero",
        o_awaddr, o_araddr, o_awlen, o_wdata, rd_data);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    logic [7:0] dv; int lat, ac, dc; logic rd;
    run_cmd(1'b1, 32'h100, 4'd3, 4'd2, 1'b0, dv, lat, ac, dc, rd);
    total++;
    if (dv !== {1'b1, 1'b1, 2'b00, 4'd2}) begin
      bad++; $display("FAIL write_done: got=%h want=%h", dv, {1'b1, 1'b1, 2'b00, 4'd2});
    end
    total++;
    if (lat != 3 + 4) begin bad++; $display("FAIL write_latency: got=%0d want=%0d", lat, 7); end
    @(negedge clk);
    total++;
    if ({done_valid, cmd_ready} !== 2'b01) begin
      bad++; $display("FAIL write_after_done: done_valid,cmd_ready got=%b want=01", {done_valid, cmd_ready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_read_single();
    logic [7:0] dv; int lat, ac, dc; logic rd;
    run_cmd(1'b0, 32'h40, 4'd0, 4'd7, 1'b0, dv, lat, ac, dc, rd);
    total++;
    if (dv !== {1'b1, 1'b0, 2'b00, 4'd7}) begin
      bad++; $display("FAIL read1_done: got=%h want=%h", dv, {1'b1, 1'b0, 2'b00, 4'd7});
    end
    total++;
    if (lat != 0 + 3) begin bad++; $display("FAIL read1_latency: got=%0d want=3", lat); end
  endtask

  task automatic test_read_resp();
    logic [7:0] dv; int lat, ac, dc; logic rd;
    rresp_tab[6] = 2'b10;   // 7th beat only
    run_cmd(1'b0, 32'h1000, 4'd15, 4'd9, 1'b0, dv, lat, ac, dc, rd);
    rresp_tab[6] = 2'b00;
    total++;
    if (dv !== {1'b1, 1'b0, 2'b10, 4'd9}) begin
      bad++; $display("FAIL read16_done: got=%h want=%h", dv, {1'b1, 1'b0, 2'b10, 4'd9});
    end
    total++;
    if (lat != 15 + 3) begin bad++; $display("FAIL read16_latency: got=%0d want=18", lat); end
  endtask

  task automatic test_write_stall();
    logic [7:0] dv; int lat, ac, dc; logic rd;
    bit seen;
    i_awready = 1'b0;
    fork
      run_cmd(1'b1, 32'h300, 4'd5, 4'hA, 1'b1, dv, lat, ac, dc, rd);
      begin
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
          @(negedge clk);
          seen = o_awvalid;
        end
        if (!seen) begin total++; bad++; $display("FAIL aw_wait: o_awvalid never rose"); end
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          total++;
          if ({o_awvalid, o_awaddr, o_awlen, o_awid} !== {1'b1, 32'h300, 4'd5, 4'hA}) begin
            bad++;
            $display("FAIL aw_stable: cycle %0d got=%h want=%h", k,
              {o_awvalid, o_awaddr, o_awlen, o_awid}, {1'b1, 32'h300, 4'd5, 4'hA});
          end
        end
        @(posedge clk); #1;
        i_awready = 1'b1;
      end
    join
    total++;
    if (dv !== {1'b1, 1'b1, 2'b00, 4'hA}) begin
      bad++; $display("FAIL stall_done: got=%h want=%h", dv, {1'b1, 1'b1, 2'b00, 4'hA});
    end
  endtask

  task automatic test_lastchk();
    logic [7:0] dv; int lat, ac, dc; logic rd;
    logic [1:0] want_resp;
    logic       want_err;
`ifdef AXI_MASTER_LASTCHK_EN
    want_resp = 2'b10; want_err = 1'b1;
`else
    want_resp = 2'b00; want_err = 1'b0;
`endif
    rlast_at = 1;   // early rlast on the 2nd of 3 beats
    run_cmd(1'b0, 32'h80, 4'd2, 4'd3, 1'b0, dv, lat, ac, dc, rd);
    rlast_at = -1;
    total++;
    if ({dv, lastchk_err} !== {1'b1, 1'b0, want_resp, 4'd3, want_err}) begin
      bad++;
      $display("FAIL lastchk_bad: got=%h want=%h", {dv, lastchk_err}, {1'b1, 1'b0, want_resp, 4'd3, want_err});
    end
    run_cmd(1'b0, 32'h90, 4'd1, 4'd4, 1'b0, dv, lat, ac, dc, rd);
    total++;
    if ({dv, lastchk_err} !== {1'b1, 1'b0, 2'b00, 4'd4, want_err}) begin
      bad++;
      $display("FAIL lastchk_sticky: got=%h want=%h", {dv, lastchk_err}, {1'b1, 1'b0, 2'b00, 4'd4, want_err});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] dv1, dv2; int lat1, lat2, ac1, ac2, dc1, dc2; logic rd1, rd2;
    bresp_val = 2'b01;
    run_cmd(1'b1, 32'h500, 4'd2, 4'd1, 1'b0, dv1, lat1, ac1, dc1, rd1);
    bresp_val = 2'b00;
    run_cmd(1'b0, 32'h600, 4'd1, 4'd4, 1'b0, dv2, lat2, ac2, dc2, rd2);
    total++;
    if ({dv1, rd1} !== {1'b1, 1'b1, 2'b01, 4'd1, 1'b0}) begin
      bad++; $display("FAIL b2b_first: done,cmd_ready got=%h want=%h", {dv1, rd1}, {1'b1, 1'b1, 2'b01, 4'd1, 1'b0});
    end
    total++;
    if (ac2 - dc1 != 2) begin bad++; $display("FAIL b2b_accept_gap: got=%0d want=2", ac2 - dc1); end
    total++;
    if ({dv2, 32'(lat2)} !== {1'b1, 1'b0, 2'b00, 4'd4, 32'd4}) begin
      bad++; $display("FAIL b2b_second: got=%h lat=%0d want done=%h lat=4", dv2, lat2, {1'b1, 1'b0, 2'b00, 4'd4});
    end
  endtask

  task automatic test_reset_midburst();
    logic [7:0] dv; int lat, ac, dc; logic rd;
    bit acc; int cnt;
    mon_en = 1'b0;
    cmd_write = 1'b1; cmd_addr = 32'h200; cmd_len = 4'd3; cmd_id = 4'd5; cmd_valid = 1'b1;
    wd_data = 32'h1234_5678; wd_strb = 4'hF; wd_valid = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk); acc = cmd_ready; @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    cnt = 0;
    for (int t = 0; t < 40 && cnt < 2; t++) begin
      @(negedge clk);
      if (o_wvalid && i_wready) cnt++;
      if (cnt < 2) begin @(posedge clk); #1; end
    end
    if (cnt < 2) begin total++; bad++; $display("FAIL rst_mid_reach: W beats seen=%0d want 2", cnt); end
    #2 rstn = 1'b0;
    #1;
    total++;
    if ({cmd_ready, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, wd_ready,
         rd_valid, done_valid, lastchk_err} !== 10'b10_0000_0000) begin
      bad++;
      $display("FAIL rst_mid_outputs: got=%b want=1000000000",
        {cmd_ready, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, wd_ready,
         rd_valid, done_valid, lastchk_err});
    end
    wd_valid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    run_cmd(1'b1, 32'h180, 4'd1, 4'd6, 1'b0, dv, lat, ac, dc, rd);
    total++;
    if ({dv, 32'(lat)} !== {1'b1, 1'b1, 2'b00, 4'd6, 32'd5}) begin
      bad++; $display("FAIL rst_mid_recover: got=%h lat=%0d want=%h lat=5", dv, lat, {1'b1, 1'b1, 2'b00, 4'd6});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
    wd_data = '0; wd_strb = '0; wd_valid = 1'b0; rd_ready = 1'b1;
    i_awready = 1'b1; i_wready = 1'b1; i_arready = 1'b1;
    bresp_val = 2'b00; rlast_at = -1; cur_id = '0;
    for (int i = 0; i < 16; i++) rresp_tab[i] = 2'b00;

    test_reset();
    test_write();
    test_read_single();
    test_read_resp();
    test_write_stall();
    test_lastchk();
    test_back_to_back();
    test_reset_midburst();

    total++;
    if (wq.size() != 0 || rq.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: w left=%0d r left=%0d want 0", wq.size(), rq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
